// File: rtl/sr_flag_pkg.sv
// Shared types and helpers for the set/reset flag bank and its round-robin reader.
package sr_flag_pkg;
    typedef enum logic {IDLE, PRESENT} state_t;

    localparam int N_FLAGS_DEF = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: lowest set bit at or above ptr, wrapping.
module rr_pick import sr_flag_pkg::*; #(
    parameter int N = N_FLAGS_DEF,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    int j;

    // Scan from the farthest offset down so the nearest hit is assigned last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end
endmodule

// File: rtl/sr_flag_reader.sv
// Sticky set/reset event flags drained one index at a time over valid/ready.
module sr_flag_reader import sr_flag_pkg::*; #(
    parameter  int N_FLAGS = N_FLAGS_DEF,
    localparam int IDX_W   = idx_w(N_FLAGS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_FLAGS-1:0] SET,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [IDX_W-1:0]   OUT_IDX,
    output logic               OUT_OVR,
    output logic [N_FLAGS-1:0] PENDING,
    output logic               OVR_ANY
);
    state_t             state;
    logic [N_FLAGS-1:0] f, ovr;
    logic [N_FLAGS-1:0] clr, keep, f_next, ovr_next;
    logic [IDX_W-1:0]   ptr, sel, out_idx;
    logic               out_valid, out_ovr, ovr_any, late, accept, found;

    rr_pick #(.N(N_FLAGS), .W(IDX_W)) u_pick (
        .req   (f),
        .ptr   (ptr),
        .found (found),
        .idx   (sel)
    );

    // A set that landed on the presented flag before acceptance survives the clear.
    always_comb begin
        accept = out_valid & OUT_READY;
        clr    = '0;
        keep   = '0;
        if (accept) begin
            clr[out_idx] = 1'b1;
            if (late) keep[out_idx] = 1'b1;
        end
        f_next   = (f & ~clr) | SET | keep;
        ovr_next = (ovr & ~clr) | (SET & f & ~clr);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            f         <= '0;
            ovr       <= '0;
            ovr_any   <= 1'b0;
            ptr       <= '0;
            out_idx   <= '0;
            out_ovr   <= 1'b0;
            out_valid <= 1'b0;
            late      <= 1'b0;
        end else begin
            f       <= f_next;
            ovr     <= ovr_next;
            ovr_any <= |ovr_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        out_idx   <= sel;
                        out_ovr   <= ovr_next[sel];
                        out_valid <= 1'b1;
                        late      <= 1'b0;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        ptr       <= (out_idx == IDX_W'(N_FLAGS - 1)) ? '0 : out_idx + IDX_W'(1);
                        out_valid <= 1'b0;
                        late      <= 1'b0;
                        state     <= IDLE;
                    end else if (SET[out_idx]) begin
                        late <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign OUT_VALID = out_valid;
    assign OUT_IDX   = out_idx;
    assign OUT_OVR   = out_ovr;
    assign PENDING   = f;
    assign OVR_ANY   = ovr_any;
endmodule
